// File: rtl/snd_out.sv
// Audio output stage: paces the sound generator, mixes its four channels,
// applies a click-free fading master gain and drives a 1-bit PDM output.
module snd_out #(
  parameter int SAMPLE_DIV   = 1536,
  parameter int FADE_SAMPLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] s3,
  input  logic [3:0] s4,
  input  logic [3:0] chan_en,
  input  logic [2:0] volume,
  input  logic       mute,
  output logic       sample_ena,
  output logic [5:0] level,
  output logic       fade_busy,
  output logic       audio_pdm
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int FADE_W = $clog2(FADE_SAMPLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              sample_ena_q, sample_ena_d;
  logic              scale_q, scale_d;
  logic [5:0]        mix_q, mix_d;
  logic [3:0]        gain_q, gain_d;
  logic [FADE_W-1:0] fcnt_q, fcnt_d;
  logic [5:0]        level_q, level_d;
  logic [5:0]        acc_q, acc_d;
  logic              pdm_q, pdm_d;

  logic [3:0]        target;
  logic [6:0]        pdm_sum;

  always_comb begin
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    sample_ena_d = (div_q == DIV_LAST);
    // scale runs one cycle behind the tick so it sees the freshly captured mix and gain
    scale_d      = sample_ena_q;
    target       = mute ? 4'd0 : {1'b0, volume} + 4'd1;

    mix_d  = mix_q;
    fcnt_d = fcnt_q;
    gain_d = gain_q;
    if (sample_ena_q) begin
      mix_d = (chan_en[0] ? {2'b00, s1} : 6'd0)
            + (chan_en[1] ? {2'b00, s2} : 6'd0)
            + (chan_en[2] ? {2'b00, s3} : 6'd0)
            + (chan_en[3] ? {2'b00, s4} : 6'd0);
      fcnt_d = fcnt_q + FADE_W'(1);
      if (&fcnt_q) begin
        if (gain_q < target) begin
          gain_d = gain_q + 4'd1;
        end else if (gain_q > target) begin
          gain_d = gain_q - 4'd1;
        end
      end
    end

    level_d = level_q;
    if (scale_q) begin
      level_d = 6'((10'(mix_q) * 10'(gain_q)) >> 3);
    end

    // first-order sigma-delta: carry out of the accumulator is the output bit
    pdm_sum = {1'b0, acc_q} + {1'b0, level_q};
    acc_d   = pdm_sum[5:0];
    pdm_d   = pdm_sum[6];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      sample_ena_q <= 1'b0;
      scale_q      <= 1'b0;
      mix_q        <= '0;
      gain_q       <= '0;
      fcnt_q       <= '0;
      level_q      <= '0;
      acc_q        <= '0;
      pdm_q        <= 1'b0;
    end else begin
      div_q        <= div_d;
      sample_ena_q <= sample_ena_d;
      scale_q      <= scale_d;
      mix_q        <= mix_d;
      gain_q       <= gain_d;
      fcnt_q       <= fcnt_d;
      level_q      <= level_d;
      acc_q        <= acc_d;
      pdm_q        <= pdm_d;
    end
  end

  assign sample_ena = sample_ena_q;
  assign level      = level_q;
  assign audio_pdm  = pdm_q;
  assign fade_busy  = (gain_q != target);

endmodule

// File: tb/tb_snd_out.sv
// Randomised bench for snd_out against a cycle-indexed behavioural model
// (tick = cycle multiple of D, gain step = tick multiple of F), plus directed scenarios.
module tb_snd_out;
  localparam int D = 8;
  localparam int F = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s1, s2, s3, s4, chan_en;
  logic [2:0] volume;
  logic       mute;
  logic       sample_ena, fade_busy, audio_pdm;
  logic [5:0] level;

  snd_out #(.SAMPLE_DIV(D), .FADE_SAMPLES(F)) dut (
    .clock(clock), .reset(reset),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .chan_en(chan_en), .volume(volume), .mute(mute),
    .sample_ena(sample_ena), .level(level),
    .fade_busy(fade_busy), .audio_pdm(audio_pdm)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] nx_s [4];
  logic [3:0] nx_chan;
  logic [2:0] nx_vol;
  logic       nx_mute;
  bit         rand_mode = 0;

  int e, mix_m, lvl_m, acc_m, gain_m;
  bit pdm_m;
  bit count_en = 0;
  int ones;
  bit track_en = 0;
  int last_lvl = 0;
  int lvl_seq[$];

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d (t=%0t)", tag, obs, exp, e, $time);
    end
  endtask

  function automatic int tgt(input bit m, input int v);
    return m ? 0 : v + 1;
  endfunction

  function automatic bit tick_at(input int c);
    return (c > 0) && (c % D == 0);
  endfunction

  task automatic model_init();
    e = 0; mix_m = 0; lvl_m = 0; acc_m = 0; gain_m = 0; pdm_m = 0;
  endtask

  task automatic drive();
    if (rand_mode) begin
      for (int i = 0; i < 4; i++) nx_s[i] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 30) == 0) nx_chan = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 50) == 0) nx_vol = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 80) == 0) nx_mute = ~nx_mute;
    end
    s1 = nx_s[0]; s2 = nx_s[1]; s3 = nx_s[2]; s4 = nx_s[3];
    chan_en = nx_chan; volume = nx_vol; mute = nx_mute;
  endtask

  // advance the model from cycle e to e+1 using the inputs present in cycle e
  task automatic step_model();
    int sum, lvl_n, t;
    int sv[4];
    sv = '{int'(s1), int'(s2), int'(s3), int'(s4)};
    sum = acc_m + lvl_m;
    lvl_n = lvl_m;
    if (e > 1 && e % D == 1) lvl_n = (mix_m * gain_m) / 8;
    if (tick_at(e)) begin
      mix_m = 0;
      for (int i = 0; i < 4; i++) if (chan_en[i]) mix_m += sv[i];
      if ((e / D) % F == 0) begin
        t = tgt(mute, int'(volume));
        if (gain_m < t) gain_m++;
        else if (gain_m > t) gain_m--;
      end
    end
    acc_m = sum % 64;
    pdm_m = (sum >= 64);
    lvl_m = lvl_n;
  endtask

  task automatic check_cycle();
    chk("sample_ena", sample_ena, tick_at(e));
    chk("level", level, lvl_m);
    chk("audio_pdm", audio_pdm, pdm_m);
    chk("fade_busy", fade_busy, gain_m != tgt(mute, int'(volume)));
    if (count_en) ones += int'(audio_pdm);
    if (track_en && int'(level) != last_lvl) begin
      lvl_seq.push_back(int'(level));
      last_lvl = int'(level);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      e++;
      check_cycle();
      drive();
      step_model();
    end
  endtask

  task automatic wait_gain(input int g, input int limit);
    int cnt = 0;
    while (gain_m != g && cnt < limit) begin
      run(1);
      cnt++;
    end
    if (cnt == limit) chk("wait_gain_timeout", gain_m, g);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    model_init();
    drive();
    step_model();
  endtask

  task automatic reset_now();
    reset = 1'b1;
    #1;
    chk("rst_sample_ena", sample_ena, 0);
    chk("rst_level", level, 0);
    chk("rst_audio_pdm", audio_pdm, 0);
    chk("rst_fade_busy", fade_busy, mute ? 0 : 1);
    @(posedge clock);
    release_reset();
  endtask

  task automatic count_window(input string tag, input int exp);
    ones = 0;
    count_en = 1;
    run(64);
    count_en = 0;
    chk(tag, ones, exp);
  endtask

  initial begin
    int exp_seq[8];
    exp_seq = '{7, 15, 22, 30, 37, 45, 52, 60};
    for (int i = 0; i < 4; i++) nx_s[i] = 4'd15;
    nx_chan = 4'hF; nx_vol = 3'd7; nx_mute = 1'b0;
    drive();
    model_init();
    #2;
    chk("rst_sample_ena", sample_ena, 0);
    chk("rst_level", level, 0);
    chk("rst_audio_pdm", audio_pdm, 0);
    chk("rst_fade_busy", fade_busy, 1);
    release_reset();

    // fade-in from silence to full scale
    track_en = 1;
    run(8 * F * D + 3 * D);
    track_en = 0;
    chk("fadein_len", lvl_seq.size(), 8);
    for (int i = 0; i < 8 && i < lvl_seq.size(); i++)
      chk($sformatf("fadein_seq%0d", i), lvl_seq[i], exp_seq[i]);
    chk("fadein_level", level, 60);
    chk("fadein_busy", fade_busy, 0);

    // mute reversal: 8 -> 5, mute for two steps, then unmute at volume 3
    nx_vol = 3'd4;
    wait_gain(5, 200);
    nx_mute = 1'b1;
    wait_gain(3, 200);
    run(3);
    chk("mute_level", level, 22);
    nx_mute = 1'b0; nx_vol = 3'd3;
    run(8 * D);
    chk("unmute_level", level, 30);
    chk("unmute_busy", fade_busy, 0);

    // channel gating at full gain
    nx_vol = 3'd7;
    wait_gain(8, 200);
    nx_s = '{4'd9, 4'd4, 4'd15, 4'd1};
    nx_chan = 4'b1001;
    run(2 * D);
    chk("gate_level", level, 10);
    nx_chan = 4'b0000;
    run(2 * D);
    chk("gate_off_level", level, 0);
    count_window("gate_off_ones", 0);

    // PDM ones density
    nx_chan = 4'hF;
    for (int i = 0; i < 4; i++) nx_s[i] = 4'd4;
    run(2 * D);
    chk("dens_level16", level, 16);
    count_window("dens16_ones", 16);
    for (int i = 0; i < 4; i++) nx_s[i] = 4'd15;
    run(2 * D);
    chk("dens_level60", level, 60);
    count_window("dens60_ones", 60);

    // randomised traffic
    rand_mode = 1;
    run(3000);
    rand_mode = 0;

    // reset mid-ramp while the PDM output is toggling
    nx_chan = 4'hF; nx_vol = 3'd7; nx_mute = 1'b0;
    for (int i = 0; i < 4; i++) nx_s[i] = 4'd15;
    reset_now();
    wait_gain(6, 400);
    run(5);
    reset_now();
    run(D);
    chk("restart_first_tick", sample_ena, 1);
    run(F * D + 3);
    chk("restart_level", level, 7);
    run(100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1);
  end

endmodule
